// File: rtl/timing_sequencer.sv
// timing_sequencer
// Step counter with a one-hot decoder. The decoder produces the timing strobes
// T0..T(N-1) for the CPU control unit. Each clock the count clears, loads,
// advances or holds. It wraps at LAST_STEP rather than at 2^W-1. WRAP flags
// each wrap, and LD_ERR flags each load whose value is out of range.
//
// Parameters:
//   W          step counter width (1..6)
//   LAST_STEP  highest step before wrap-around (0..2^W-1)
// Ports:
//   CLK     system clock, rising edge
//   RST     synchronous active-high reset
//   CLR     synchronous clear of the step count
//   LD      load LD_VAL (saturates at LAST_STEP)
//   LD_VAL  value to load
//   INC     advance the step count by one, modulo LAST_STEP+1
//   EN      output enable for OUT only
//   STEP    registered step count
//   OUT     one-hot decode of STEP gated by EN (combinational)
//   WRAP    one-cycle pulse after a LAST_STEP -> 0 increment
//   LD_ERR  one-cycle pulse after a load with LD_VAL > LAST_STEP
module timing_sequencer #(
  parameter int W         = 4,
  parameter int LAST_STEP = (1 << W) - 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR,
  input  logic                LD,
  input  logic [W-1:0]        LD_VAL,
  input  logic                INC,
  input  logic                EN,
  output logic [W-1:0]        STEP,
  output logic [(1<<W)-1:0]   OUT,
  output logic                WRAP,
  output logic                LD_ERR
);

  localparam int N = 1 << W;

  // Reject parameter sets that cannot be built.
  if (W < 1 || W > 6) begin : g_bad_w
    $fatal(1, "timing_sequencer: W=%0d outside legal range 1..6", W);
  end
  if (LAST_STEP < 0 || LAST_STEP > N - 1) begin : g_bad_last
    $fatal(1, "timing_sequencer: LAST_STEP=%0d outside legal range 0..%0d",
           LAST_STEP, N - 1);
  end

  localparam logic [W-1:0] LAST_VAL = W'(LAST_STEP);

  logic [W-1:0] step_reg, step_next;
  logic         wrap_reg, wrap_next;
  logic         ld_err_reg, ld_err_next;

  // Command decode in priority order CLR > LD > INC > hold. RST is handled in
  // the register block. Both pulses default low, so each pulse lasts exactly
  // one cycle unless the same event happens again.
  always_comb begin
    step_next   = step_reg;
    wrap_next   = 1'b0;
    ld_err_next = 1'b0;
    if (CLR) begin
      step_next = '0;
    end else if (LD) begin
      if (LD_VAL > LAST_VAL) begin
        step_next   = LAST_VAL;
        ld_err_next = 1'b1;
      end else begin
        step_next = LD_VAL;
      end
    end else if (INC) begin
      if (step_reg == LAST_VAL) begin
        // This branch also covers LAST_STEP = 0: the count stays at 0 and
        // every INC raises WRAP.
        step_next = '0;
        wrap_next = 1'b1;
      end else begin
        step_next = step_reg + W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      step_reg   <= '0;
      wrap_reg   <= 1'b0;
      ld_err_reg <= 1'b0;
    end else begin
      step_reg   <= step_next;
      wrap_reg   <= wrap_next;
      ld_err_reg <= ld_err_next;
    end
  end

  assign STEP   = step_reg;
  assign WRAP   = wrap_reg;
  assign LD_ERR = ld_err_reg;

  // Decoder: strobes above LAST_STEP are tied low. STEP can never reach those
  // values, so their compare logic is not needed.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    if (gi > LAST_STEP) begin : g_unused
      assign OUT[gi] = 1'b0;
    end else begin : g_used
      assign OUT[gi] = EN && (step_reg == W'(gi));
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Testbench for timing_sequencer. It builds three W=4 instances with
// LAST_STEP = 15, 9 and 0, and drives them from one shared set of inputs.
// A reference model computes each expected count from the command rules using
// plain modular arithmetic. A directed sequence runs first, then randomized
// commands.
module tb_timing_sequencer;

  localparam int NDUT = 3;
  localparam int LASTS [NDUT] = '{15, 9, 0};

  logic        clk = 1'b0;
  logic        rst, clr, ld, inc, en;
  logic [3:0]  ld_val;
  logic [3:0]  step_o   [NDUT];
  logic [15:0] out_o    [NDUT];
  logic        wrap_o   [NDUT];
  logic        ld_err_o [NDUT];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  int m_step [NDUT];
  int m_wrap [NDUT];
  int m_err  [NDUT];
  int cyc = 0;

  always #5 clk = ~clk;

  timing_sequencer #(.W(4), .LAST_STEP(15)) dut_full (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .INC(inc), .EN(en),
    .STEP(step_o[0]), .OUT(out_o[0]), .WRAP(wrap_o[0]), .LD_ERR(ld_err_o[0]));

  timing_sequencer #(.W(4), .LAST_STEP(9)) dut_nine (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .INC(inc), .EN(en),
    .STEP(step_o[1]), .OUT(out_o[1]), .WRAP(wrap_o[1]), .LD_ERR(ld_err_o[1]));

  timing_sequencer #(.W(4), .LAST_STEP(0)) dut_zero (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .LD_VAL(ld_val), .INC(inc), .EN(en),
    .STEP(step_o[2]), .OUT(out_o[2]), .WRAP(wrap_o[2]), .LD_ERR(ld_err_o[2]));

  task automatic chk(input string tag, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", tag, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_out(input int k);
    return en ? (16'h1 << m_step[k]) : 16'h0;
  endfunction

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk("step",   k, 32'(step_o[k]),   32'(m_step[k]));
      chk("out",    k, 32'(out_o[k]),    32'(exp_out(k)));
      chk("wrap",   k, 32'(wrap_o[k]),   32'(m_wrap[k]));
      chk("ld_err", k, 32'(ld_err_o[k]), 32'(m_err[k]));
    end
  endtask

  // Apply one set of commands for one clock edge, advance the model, then
  // check every instance 1 ns after the edge.
  task automatic cycle(input logic r, input logic c, input logic l,
                       input logic [3:0] v, input logic i, input logic e);
    rst = r; clr = c; ld = l; ld_val = v; inc = i; en = e;
    for (int k = 0; k < NDUT; k++) begin
      m_wrap[k] = 0;
      m_err[k]  = 0;
      if (r || c) begin
        m_step[k] = 0;
      end else if (l) begin
        if (int'(v) > LASTS[k]) begin
          m_step[k] = LASTS[k];
          m_err[k]  = 1;
        end else begin
          m_step[k] = int'(v);
        end
      end else if (i) begin
        m_wrap[k] = (m_step[k] == LASTS[k]) ? 1 : 0;
        m_step[k] = (m_step[k] + 1) % (LASTS[k] + 1);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%b clr=%b ld=%b v=%0d inc=%b en=%b | step %0d/%0d/%0d wrap %b%b%b err %b%b%b",
             cyc, r, c, l, v, i, e, step_o[0], step_o[1], step_o[2],
             wrap_o[0], wrap_o[1], wrap_o[2], ld_err_o[0], ld_err_o[1], ld_err_o[2]);
    check_all();
  endtask

  // Change only EN and check OUT without a clock edge.
  task automatic en_only(input logic e);
    en = e;
    #1;
    $display("en -> %b | out %h/%h/%h", e, out_o[0], out_o[1], out_o[2]);
    for (int k = 0; k < NDUT; k++) chk("en_out", k, 32'(out_o[k]), 32'(exp_out(k)));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; inc = 1'b0; en = 1'b1; ld_val = '0;
    for (int k = 0; k < NDUT; k++) begin
      m_step[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end
    @(negedge clk);

    // Reset state.
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    chk("reset_out", 0, 32'(out_o[0]), 32'h0001);

    // Free run for 20 cycles.
    for (int n = 0; n < 20; n++) begin
      cycle(0, 0, 0, 0, 1, 1);
      if (n == 15) chk("wrap16", 0, 32'(wrap_o[0]), 32'd1);
    end
    chk("run_step", 0, 32'(step_o[0]), 32'd4);

    // Loads on the LAST_STEP=9 instance.
    cycle(0, 0, 1, 4'd5, 0, 1);
    chk("ld5_out", 1, 32'(out_o[1]), 32'h0020);
    cycle(0, 0, 1, 4'd12, 0, 1);
    chk("ld12_step", 1, 32'(step_o[1]), 32'd9);
    chk("ld12_err", 1, 32'(ld_err_o[1]), 32'd1);
    cycle(0, 0, 0, 0, 0, 1);   // hold: LD_ERR drops after one cycle

    // Priority at STEP=9.
    cycle(0, 0, 1, 4'd9, 0, 1);
    cycle(0, 1, 1, 4'd3, 1, 1);
    chk("prio_clr", 1, 32'(step_o[1]), 32'd0);
    cycle(0, 0, 1, 4'd3, 1, 1);
    chk("prio_ld", 1, 32'(step_o[1]), 32'd3);

    // Enable and hold.
    cycle(0, 0, 1, 4'd7, 0, 1);
    en_only(1'b0);
    cycle(0, 0, 0, 0, 0, 0);
    en_only(1'b1);
    chk("en_7", 1, 32'(out_o[1]), 32'h0080);

    // Reset while a wrap is pending.
    cycle(0, 0, 1, 4'd9, 0, 1);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);

    // Short sequence: more than two periods of the LAST_STEP=9 instance.
    for (int n = 0; n < 25; n++) cycle(0, 0, 0, 0, 1, 1);

    // Randomized commands.
    for (int n = 0; n < 400; n++) begin
      automatic int p = $urandom_range(99);
      cycle((p < 2), ($urandom_range(99) < 6), ($urandom_range(99) < 15),
            4'($urandom_range(15)), ($urandom_range(99) < 70),
            ($urandom_range(99) < 85));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
